prbs_checker: RTL and testbench

// Serial pseudo-random bit-sequence checker: the receive end for the Fibonacci LFSR

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/prbs_checker_err_cnt.sv | 34 +++
 rtl/prbs_checker.sv | 154 +++++++++++++++
 tb/tb_prbs_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Types and helpers shared by the PRBS generator and checker.
package lfsr_pkg;

    typedef enum logic [1:0] {
        FILL,
        HUNT,
        LOCKED
    } sync_state_t;

    localparam int LFSR_LEN = 16;
    localparam logic [0:LFSR_LEN-1] TAPS_16 = 16'b0110100000000001;

    // Feedback bit: XOR of the tapped state bits, state indexed [0:LEN-1].
    function automatic logic lfsr_fb(input logic [0:LFSR_LEN-1] state,
                                     input logic [0:LFSR_LEN-1] taps);
        return ^(taps & state);
    endfunction

endpackage

// File: rtl/prbs_checker_err_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority over enable).
module prbs_err_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: fills, hunts for a run of predicted bits,
// then free-runs its own LFSR and counts mismatches with windowed loss-of-lock.
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int                 LENGTH    = LFSR_LEN,
    parameter logic [0:LENGTH-1]  TAPS      = TAPS_16,
    parameter int                 LOCK_CNT  = 32,
    parameter int                 LOSS_WIN  = 64,
    parameter int                 LOSS_ERRS = 8,
    parameter int                 CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W  = $clog2(LENGTH);
    localparam int RUN_W   = $clog2(LOCK_CNT);
    localparam int WBEAT_W = $clog2(LOSS_WIN);
    localparam int WERR_W  = $clog2(LOSS_ERRS + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LENGTH - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(LOCK_CNT - 1);
    localparam logic [WBEAT_W-1:0] WBEAT_LAST = WBEAT_W'(LOSS_WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_TRIP  = WERR_W'(LOSS_ERRS);

    sync_state_t         state_q, state_d;
    logic [0:LENGTH-1]   sreg_q, sreg_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [WBEAT_W-1:0]  wbeat_q, wbeat_d;
    logic [WERR_W-1:0]   werr_q, werr_d;
    logic [WERR_W-1:0]   werr_nxt;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic                bit_en, err_en;

    logic pred;
    logic mism;

    assign pred = lfsr_fb(sreg_q, TAPS);
    assign mism = (in_bit != pred);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            sreg_q      <= '0;
            fill_q      <= FILL_LAST;
            run_q       <= '0;
            wbeat_q     <= '0;
            werr_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            wbeat_q     <= wbeat_d;
            werr_q      <= werr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        fill_d   = fill_q;
        run_d    = run_q;
        wbeat_d  = wbeat_q;
        werr_d   = werr_q;
        werr_nxt = werr_q + (mism ? WERR_W'(1) : WERR_W'(0));
        if (in_valid) begin
            unique case (state_q)
                FILL: begin
                    sreg_d = {in_bit, sreg_q[0:LENGTH-2]};
                    if (fill_q == '0) begin
                        state_d = HUNT;
                        fill_d  = FILL_LAST;
                    end else begin
                        fill_d = fill_q - FILL_W'(1);
                    end
                end
                HUNT: begin
                    sreg_d = {in_bit, sreg_q[0:LENGTH-2]};
                    // An all-zero register predicts zeros forever; never accept it.
                    if (!mism && (sreg_q != '0)) begin
                        if (run_q == RUN_LAST) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    sreg_d = {pred, sreg_q[0:LENGTH-2]};
                    // Threshold is checked before the window rolls over.
                    if (werr_nxt == WERR_TRIP) begin
                        state_d = FILL;
                        fill_d  = FILL_LAST;
                        run_d   = '0;
                        wbeat_d = '0;
                        werr_d  = '0;
                    end else if (wbeat_q == WBEAT_LAST) begin
                        wbeat_d = '0;
                        werr_d  = '0;
                    end else begin
                        wbeat_d = wbeat_q + WBEAT_W'(1);
                        werr_d  = werr_nxt;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_comb begin
        locked_d    = (state_d == LOCKED);
        bit_en      = in_valid && (state_q == LOCKED);
        err_pulse_d = bit_en && mism;
        err_en      = err_pulse_d;
    end

    prbs_err_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (err_en),
        .count (err_count)
    );

    prbs_err_cnt #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (bit_en),
        .count (bit_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, loss/relock, zero stream,
// gaps/clear/async reset, and counter saturation on a narrow-counter instance.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        locked, err_pulse;
    logic [31:0] err_count, bit_count;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_count_s, bit_count_s;

    int n_vec  = 0;
    int n_miss = 0;

    logic [0:15] g;
    int          lk;

    always #5 clk = ~clk;

    prbs_checker u_dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    prbs_checker #(.CNT_W(4)) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .locked    (locked_s),
        .err_pulse (err_pulse_s),
        .err_count (err_count_s),
        .bit_count (bit_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Generator model: taps at state indices 1, 2, 4, 15; output is the new state[0].
    task automatic gen_bit(output logic b);
        b = g[1] ^ g[2] ^ g[4] ^ g[15];
        g = {b, g[0:14]};
    endtask

    task automatic beat(input logic v, input logic b, input logic c);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_beat(input logic flip, input logic c);
        logic b;
        gen_bit(b);
        beat(1'b1, b ^ flip, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        g = 16'h0001;
    endtask

    initial begin
        logic seen;
        int   nvalid;
        int   lock_at;
        int   pad;

        // T1: reset values and lock timing
        do_reset();
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_bit_count", bit_count, 0);
        seen = 1'b0;
        for (int i = 0; i < 47; i++) begin
            gen_beat(1'b0, 1'b0);
            seen |= locked;
        end
        chk("t1_no_early_lock", seen, 0);
        gen_beat(1'b0, 1'b0);
        chk("t1_lock_at_48", locked, 1);
        chk("t1_bitcnt_at_lock", bit_count, 0);
        for (int i = 48; i < 1000; i++) gen_beat(1'b0, 1'b0);
        chk("t1_err_count", err_count, 0);
        chk("t1_bit_count", bit_count, 952);
        lk = 952;

        // T2: single inverted bit
        gen_beat(1'b1, 1'b0);
        chk("t2_pulse", err_pulse, 1);
        chk("t2_err_count", err_count, 1);
        chk("t2_locked", locked, 1);
        beat(1'b0, 1'b0, 1'b0);
        chk("t2_idle_pulse", err_pulse, 0);
        chk("t2_idle_bitcnt", bit_count, 953);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            gen_beat(1'b0, 1'b0);
            seen |= err_pulse;
        end
        chk("t2_no_more_pulse", seen, 0);
        chk("t2_err_count_hold", err_count, 1);
        lk += 101;

        // T3: loss of lock within one window, then relock
        pad = (64 - (lk % 64)) % 64;
        for (int i = 0; i < pad; i++) gen_beat(1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b1);
        chk("t3_clr_err", err_count, 0);
        chk("t3_clr_bit", bit_count, 0);
        for (int i = 0; i < 7; i++) gen_beat(1'b1, 1'b0);
        chk("t3_locked_after7", locked, 1);
        chk("t3_errs_after7", err_count, 7);
        gen_beat(1'b1, 1'b0);
        chk("t3_unlock_after8", locked, 0);
        chk("t3_errs_after8", err_count, 8);
        chk("t3_pulse8", err_pulse, 1);
        seen = 1'b0;
        for (int i = 0; i < 47; i++) begin
            gen_beat(1'b0, 1'b0);
            seen |= locked;
        end
        chk("t3_no_early_relock", seen, 0);
        gen_beat(1'b0, 1'b0);
        chk("t3_relock_48", locked, 1);
        chk("t3_err_retained", err_count, 8);
        chk("t3_bit_retained", bit_count, 8);

        // T4: all-zero stream never locks
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            beat(1'b1, 1'b0, 1'b0);
            seen |= locked;
        end
        chk("t4_never_locked", seen, 0);
        chk("t4_err_count", err_count, 0);
        chk("t4_bit_count", bit_count, 0);

        // T5: gaps, clr with errored beat, async reset
        do_reset();
        nvalid  = 0;
        lock_at = 0;
        for (int i = 0; i < 400 && lock_at == 0; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                gen_beat(1'b0, 1'b0);
                nvalid++;
            end else begin
                beat(1'b0, 1'b0, 1'b0);
            end
            if (locked && lock_at == 0) lock_at = nvalid;
        end
        chk("t5_gap_lock_beats", lock_at, 48);
        gen_beat(1'b1, 1'b1);
        chk("t5_clr_err_count", err_count, 0);
        chk("t5_clr_bit_count", bit_count, 0);
        chk("t5_clr_pulse", err_pulse, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_arst_locked", locked, 0);
        chk("t5_arst_pulse", err_pulse, 0);
        chk("t5_arst_err", err_count, 0);
        chk("t5_arst_bit", bit_count, 0);
        in_valid = 1'b0;
        clr = 1'b0;

        // T6: saturation on the 4-bit-counter instance
        do_reset();
        for (int i = 0; i < 48; i++) gen_beat(1'b0, 1'b0);
        chk("t6_locked", locked_s, 1);
        for (int e = 0; e < 20; e++) begin
            for (int i = 0; i < 15; i++) gen_beat(1'b0, 1'b0);
            gen_beat(1'b1, 1'b0);
        end
        chk("t6_still_locked", locked_s, 1);
        chk("t6_err_sat", err_count_s, 15);
        chk("t6_bit_sat", bit_count_s, 15);
        chk("t6_err_wide", err_count, 20);
        chk("t6_bit_wide", bit_count, 320);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
